vadd_seq: RTL

VADD_SEQ -- requirements
Module: vadd_seq

---
 rtl/vadd_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/vadd_seq.sv
// Sequential FP16 vector adder: walks LANES lanes through one external adder.
// Optional subtract mode (add_b sign flipped) enabled by defining VADD_SEQ_SUB_EN.
module vadd_seq #(
  parameter int LANES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef VADD_SEQ_SUB_EN
  input  logic                  sub,
`endif
  input  logic [16*LANES-1:0]   vec_a,
  input  logic [16*LANES-1:0]   vec_b,
  output logic [15:0]           add_a,
  output logic [15:0]           add_b,
  input  logic [15:0]           add_sum,
  input  logic                  add_ovf,
  output logic                  busy,
  output logic                  done,
  output logic [16*LANES-1:0]   vec_sum,
  output logic [LANES-1:0]      ovf_mask,
  output logic                  ovf_any
);

  localparam int unsigned CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      a_q   [LANES];
  logic [15:0]      a_d   [LANES];
  logic [15:0]      b_q   [LANES];
  logic [15:0]      b_d   [LANES];
  logic [15:0]      sum_q [LANES];
  logic [15:0]      sum_d [LANES];
  logic [LANES-1:0] ovf_q, ovf_d;
  logic [15:0]      va    [LANES];
  logic [15:0]      vb    [LANES];
  logic             sub_q, sub_d;
  logic             sub_in;

`ifdef VADD_SEQ_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign va[g]               = vec_a[16*g +: 16];
    assign vb[g]               = vec_b[16*g +: 16];
    assign vec_sum[16*g +: 16] = sum_q[g];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    sub_d   = sub_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = va;
          b_d     = vb;
          sub_d   = sub_in;
          cnt_d   = '0;
          sum_d   = '{default: '0};
          ovf_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[cnt_q] = add_sum;
        ovf_d[cnt_q] = add_ovf;
        // Wrap to zero on the last lane so cnt never exceeds LANES-1.
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sum_q   <= '{default: '0};
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  // Captured operands need no reset: they are only observed in RUN.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sub_q <= sub_d;
  end

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state_q == S_RUN) begin
      add_a = a_q[cnt_q];
      add_b = b_q[cnt_q] ^ {sub_q, 15'b0};
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign ovf_mask = ovf_q;
  assign ovf_any  = |ovf_q;

endmodule
